mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: address width of every port.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width; byte-enable width is DATA_W/8.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: cycles allowed per bus transaction (timeout build only).
REQ-004 The block SHALL have these ports: clk  in  1  sole clock, rising edge.
REQ-005 The block SHALL have these ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have these ports: if_req  in  1  fetch request, held until if_ack.
REQ-007 The block SHALL have these ports: if_addr  in  ADDR_W  fetch address.
REQ-008 The block SHALL have these ports: if_flush  in  1  discard any fetch in flight (pc_src_e redirect).
REQ-009 The block SHALL have these ports: if_rdata  out  DATA_W, if_ack  out  1  fetch data and 1-cycle completion pulse.
REQ-010 The block SHALL have these ports: dm_req  in  1, dm_we  in  1, dm_be  in  DATA_W/8, dm_addr  in  ADDR_W, dm_wdata  in  DATA_W  data-stage access, held until dm_ack.
REQ-011 The block SHALL have these ports: dm_rdata  out  DATA_W, dm_ack  out  1  load data and 1-cycle completion pulse.
REQ-012 The block SHALL have these ports: bus_req  out  1, bus_we  out  1, bus_be  out  DATA_W/8, bus_addr  out  ADDR_W, bus_wdata  out  DATA_W  shared memory port.
REQ-013 The block SHALL have these ports: bus_rdata  in  DATA_W, bus_ack  in  1  memory response.
REQ-014 The block SHALL have these ports: stall_if  out  1, stall_mem  out  1  stall requests to the hazard unit; bus_err  out  1  timeout pulse.

Function
REQ-015 FSM states SHALL be IDLE, IF_TXN, DM_TXN; one transaction outstanding at a time.
REQ-016 In IDLE, with only one request pending, that requester SHALL be granted; with both pending, grant SHALL go to dm unless the previous grant was dm, then to if (no fetch starvation).
REQ-017 On grant, address/we/be/wdata SHALL be registered and the FSM SHALL enter IF_TXN or DM_TXN the next cycle; bus outputs SHALL be driven only from registers.
REQ-018 bus_req SHALL be 1 in IF_TXN/DM_TXN until the cycle bus_ack is sampled 1, and 0 otherwise; bus_we is 0 for fetches.
REQ-019 On bus_ack, bus_rdata SHALL be registered to if_rdata or dm_rdata, the matching ack pulses for exactly the next cycle, FSM returns to IDLE; minimum latency request->ack = 2 cycles.
REQ-020 A new grant SHALL NOT be issued in the cycle an ack pulses (requester deasserts or re-presents next cycle).
REQ-021 stall_if SHALL equal if_req & ~if_ack; stall_mem SHALL equal dm_req & ~dm_ack (combinational).
REQ-022 if_flush asserted during IF_TXN or the grant cycle SHALL mark the fetch dropped: bus transaction completes, if_ack suppressed, if_rdata unchanged.
REQ-023 if_flush in IDLE SHALL block an if grant that cycle; dm transactions SHALL be unaffected by if_flush.
REQ-024 bus_ack while IDLE SHALL be ignored.

Reset
REQ-025 On rst_n low, FSM SHALL go to IDLE, last-grant flag to if, all outputs and registers to 0, immediately and asynchronously.
REQ-026 Reset mid-transaction SHALL abandon it; no ack SHALL pulse after release until a new grant completes.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined, a counter SHALL clear on grant and increment each TXN cycle; reaching TIMEOUT without bus_ack SHALL abort: bus_req drops, requester ack pulses with rdata 0, bus_err pulses 1 cycle, FSM to IDLE.
REQ-028 Without ARB_TIMEOUT_EN, no counter SHALL exist, bus_err SHALL be tied 0, and transactions SHALL wait for bus_ack indefinitely.

Verification
REQ-029 Fetch alone: if_req=1, if_addr=0x100, bus_ack one cycle after bus_req with bus_rdata=0x00500093 -> bus_addr=0x100, if_ack pulse at request+2, if_rdata=0x00500093.
REQ-030 Contention: if_req and dm_req (load 0x2000) both high from IDLE, last grant=if -> dm served first, stall_if=1 throughout, then fetch granted; with both high again after that, next grant=if.
REQ-031 Store: dm_we=1, dm_be=4'b0011, dm_wdata=0xDEADBEEF -> bus_we=1, bus_be=4'b0011, bus_wdata=0xDEADBEEF until bus_ack, dm_ack one pulse.
REQ-032 Flush: if_flush pulse during IF_TXN, bus_ack 3 cycles later -> no if_ack, if_rdata unchanged, FSM IDLE.
REQ-033 Reset: rst_n low during DM_TXN -> bus_req 0 and state IDLE without waiting for clk; no dm_ack after release.
REQ-034 Timeout (ARB_TIMEOUT_EN, TIMEOUT=16): bus_ack never asserted -> after 16 TXN cycles bus_err and dm_ack pulse once, dm_rdata=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data-stage arbiter onto one shared memory port (optional ARB_TIMEOUT_EN)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ack,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, IF_TXN, DM_TXN} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_dm;
    logic                r_if_drop;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [BE_W-1:0]     r_bus_be;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_if_ack;
    logic                r_dm_ack;
    logic                w_grant_if;
    logic                w_grant_dm;
    logic                w_grant;
    logic                w_if_ok;
    logic                w_txn;
    logic                w_abort;
    logic                w_end;
    logic [DATA_W-1:0]   w_rdata;

    assign w_if_ok = if_req & ~if_flush;
    assign w_txn   = (r_state != IDLE);
    assign w_grant = w_grant_if | w_grant_dm;
    assign w_end   = w_txn & (bus_ack | w_abort);
    // An aborted transaction returns zero data to the requester.
    assign w_rdata = bus_ack ? bus_rdata : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    assign w_abort = w_txn & ~bus_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
    assign bus_err = r_bus_err;

    // Count transaction cycles since grant; flag a one-cycle error on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if (w_grant)
                r_cnt <= '0;
            else if (w_txn)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_abort          = 1'b0;
    assign bus_err          = 1'b0;
`endif

    // Arbitration and next state; dm wins ties unless it had the last grant.
    always_comb begin
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!r_if_ack && !r_dm_ack) begin
                    if (dm_req && (!w_if_ok || !r_last_dm)) begin
                        w_grant_dm   = 1'b1;
                        w_next_state = DM_TXN;
                    end else if (w_if_ok) begin
                        w_grant_if   = 1'b1;
                        w_next_state = IF_TXN;
                    end
                end
            end
            IF_TXN, DM_TXN: begin
                if (w_end)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register and last-grant flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last_dm <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant)
                r_last_dm <= w_grant_dm;
        end
    end

    // Capture the granted request; bus pins come only from these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_grant) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_grant_dm & dm_we;
            r_bus_be    <= w_grant_dm ? dm_be : {BE_W{1'b1}};
            r_bus_addr  <= w_grant_dm ? dm_addr : if_addr;
            r_bus_wdata <= w_grant_dm ? dm_wdata : '0;
        end else if (w_end) begin
            r_bus_req   <= 1'b0;
        end
    end

    // Completion: latch read data and pulse the owner's ack; a flushed fetch stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_drop  <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            if (w_grant)
                r_if_drop <= 1'b0;
            else if (r_state == IF_TXN && if_flush)
                r_if_drop <= 1'b1;
            if (w_end && r_state == DM_TXN) begin
                r_dm_rdata <= w_rdata;
                r_dm_ack   <= 1'b1;
            end
            if (w_end && r_state == IF_TXN && !r_if_drop && !if_flush) begin
                r_if_rdata <= w_rdata;
                r_if_ack   <= 1'b1;
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ack    = r_dm_ack;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_be    = r_bus_be;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    int          checks   = 0;
    int          failures = 0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        stray     = 1'b0;
    logic [32:0] if_q[$];
    logic [32:0] dm_q[$];
    bus_t        bus_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_f = 32'h0050_0093;
            32'h0000_2000: mem_f = 32'h1234_5678;
            default:       mem_f = a ^ 32'hCAFE_0000;
        endcase
    endfunction

    // Memory model: acks after ack_delay request cycles, checks bus fields every request cycle.
    always @(negedge clk) begin
        if (stray) begin
            bus_ack   = 1'b1;
            bus_rdata = 32'hBAD0_BAD0;
        end else if (bus_req) begin
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected actual=addr 0x%0h required=no request", bus_addr);
            end else begin
                check("bus_we", bus_we, bus_q[0].we);
                check("bus_be", bus_be, bus_q[0].be);
                check("bus_addr", bus_addr, bus_q[0].addr);
                check("bus_wdata", bus_wdata, bus_q[0].wdata);
            end
            if (wait_cnt >= ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = mem_f(bus_addr);
                wait_cnt  = 0;
                if (bus_q.size() != 0)
                    void'(bus_q.pop_front());
            end else begin
                bus_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Ack monitor: every ack pops the matching expectation queue.
    always @(negedge clk) begin
        logic [32:0] e;
        if (if_ack) begin
            if (if_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL if_ack_unexpected actual=1 required=0");
            end else begin
                e = if_q.pop_front();
                if (e[32]) check("if_rdata", if_rdata, e[31:0]);
            end
        end
        if (dm_ack) begin
            if (dm_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dm_ack_unexpected actual=1 required=0");
            end else begin
                e = dm_q.pop_front();
                if (e[32]) check("dm_rdata", dm_rdata, e[31:0]);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, output int cyc);
        logic done = 1'b0;
        if_req  = 1'b1;
        if_addr = a;
        cyc     = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (if_ack) done = 1'b1;
            else check("stall_if_wait", stall_if, 1);
        end
        if (!done) check("fetch_timeout", 0, 1);
        else check("stall_if_ack", stall_if, 0);
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, output int cyc);
        logic done = 1'b0;
        dm_req   = 1'b1;
        dm_we    = we;
        dm_be    = be;
        dm_addr  = a;
        dm_wdata = wd;
        cyc      = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (dm_ack) done = 1'b1;
            else check("stall_mem_wait", stall_mem, 1);
        end
        if (!done) check("dm_timeout", 0, 1);
        else check("stall_mem_ack", stall_mem, 0);
        dm_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c1, c2, c3;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_dm_ack", dm_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone fetch, memory acks in the first request cycle.
        ack_delay = 0;
        if_q.push_back({1'b1, 32'h0050_0093});
        bus_q.push_back('{1'b0, 4'hF, 32'h100, 32'h0});
        do_fetch(32'h100, c);
        check("fetch_latency", c, 2);
        @(negedge clk);

        // Contention after an if grant: dm, then if, then re-presented dm.
        ack_delay = 1;
        dm_q.push_back({1'b1, 32'h1234_5678});
        if_q.push_back({1'b1, 32'hCAFE_0300});
        dm_q.push_back({1'b1, 32'hCAFE_2004});
        bus_q.push_back('{1'b0, 4'hF, 32'h2000, 32'h0});
        bus_q.push_back('{1'b0, 4'hF, 32'h300, 32'h0});
        bus_q.push_back('{1'b0, 4'hF, 32'h2004, 32'h0});
        fork
            begin
                do_dm(1'b0, 4'hF, 32'h2000, 32'h0, c1);
                do_dm(1'b0, 4'hF, 32'h2004, 32'h0, c2);
            end
            do_fetch(32'h300, c3);
        join
        check("contention_dm_first", c1, 3);
        check("contention_if_second", c3, 7);
        @(negedge clk);

        // Partial store.
        ack_delay = 2;
        dm_q.push_back({1'b0, 32'h0});
        bus_q.push_back('{1'b1, 4'b0011, 32'h3000, 32'hDEAD_BEEF});
        do_dm(1'b1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, c);
        check("store_latency", c, 4);
        @(negedge clk);

        // Flush during IF_TXN: bus completes, no if_ack, if_rdata kept.
        ack_delay = 3;
        bus_q.push_back('{1'b0, 4'hF, 32'h400, 32'h0});
        if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk);
        check("flush_bus_req", bus_req, 1);
        if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0; if_req = 1'b0;
        repeat (6) @(negedge clk);
        check("flush_if_rdata", if_rdata, 32'hCAFE_0300);
        check("flush_idle", bus_req, 0);
        check("flush_bus_done", bus_q.size(), 0);

        // Flush in IDLE blocks the fetch grant for that cycle.
        if_req = 1'b1; if_addr = 32'h500; if_flush = 1'b1;
        @(negedge clk);
        check("flush_idle_block", bus_req, 0);
        if_flush = 1'b0;
        ack_delay = 0;
        if_q.push_back({1'b1, 32'hCAFE_0500});
        bus_q.push_back('{1'b0, 4'hF, 32'h500, 32'h0});
        do_fetch(32'h500, c);
        check("fetch_after_flush", c, 2);
        @(negedge clk);

        // Stray bus_ack while idle.
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_bus_req", bus_req, 0);
        check("stray_if_ack", if_ack, 0);
        check("stray_dm_ack", dm_ack, 0);

        // Asynchronous reset in DM_TXN.
        ack_delay = 1000;
        bus_q.push_back('{1'b0, 4'hF, 32'h5000, 32'h0});
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h5000; dm_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_pre_bus_req", bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_bus_req", bus_req, 0);
        check("rst_async_if_rdata", if_rdata, 0);
        dm_req = 1'b0;
        bus_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        repeat (5) @(negedge clk);
        check("rst_no_dm_ack", dm_ack, 0);
        check("rst_idle", bus_req, 0);

`ifdef ARB_TIMEOUT_EN
        // No bus_ack: abort after 16 transaction cycles.
        ack_delay = 1000;
        bus_q.push_back('{1'b0, 4'hF, 32'h6000, 32'h0});
        dm_q.push_back({1'b1, 32'h0});
        do_dm(1'b0, 4'hF, 32'h6000, 32'h0, c);
        check("timeout_latency", c, 17);
        check("timeout_bus_err", bus_err, 1);
        @(negedge clk);
        check("timeout_bus_err_pulse", bus_err, 0);
        check("timeout_bus_req", bus_req, 0);
        bus_q.delete();
        ack_delay = 0;
`else
        check("bus_err_tied", bus_err, 0);
`endif

        repeat (2) @(negedge clk);
        check("if_q_empty", if_q.size(), 0);
        check("dm_q_empty", dm_q.size(), 0);
        check("bus_q_empty", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
